fun_sweep_checker: RTL
======================

// Module: fun_sweep_checker
// PURPOSE
//  Hardware self-test sequencer for the combinational 3-input/1-output `fun` block.
//  - Sweeps the input code 0..2^IN_W-1 on `dut_in` and waits SETTLE cycles per code.
//  - Samples `dut_out` and compares it against a parameterised truth table.
//  - Reports a per-code fail map, an error count and a pass flag.
//  - Sits beside `fun` as the response-capturing end of its interface: the on-chip
//    counterpart of the stimulus side.
// PARAMETERS
//  IN_W      3             width of dut_in; VEC_N = 2**IN_W codes swept
//  SETTLE    4             cycles each code is held before sampling; must be >= 1
//  EXPECTED  8'b1001_0110  golden truth table; bit i = expected dut_out for dut_in==i
//                          (default = odd parity of the 3 inputs)
// PORTS
//  clock     in   1        single clock; all state changes on rising edge
//  reset     in   1        synchronous, active-high
//  start     in   1        begin sweep; sampled only in IDLE
//  dut_in    out  IN_W     code driven to `fun`
//  dut_out   in   1        `fun` output, sampled in SAMPLE state
//  busy      out  1        high in DRIVE and SAMPLE
//  done      out  1        one-cycle pulse when sweep completes
//  pass      out  1        1 if last completed sweep had zero mismatches; held until next start
//  err_count out  IN_W+1   mismatches in current/last sweep (max VEC_N)
//  fail_map  out  VEC_N    bit i set if code i mismatched; held until next start
// BEHAVIOUR
//  Reset (sync, wins over everything):
//   - state=IDLE.
//   - dut_in, counters, busy, done, pass, err_count and fail_map all = 0.
//  States: IDLE -> DRIVE -> SAMPLE -> (DRIVE | DONE) -> IDLE.
//  IDLE:
//   - dut_in=0.
//   - start=1 -> DRIVE; clear idx, settle count, err_count, fail_map and pass on the same edge.
//  DRIVE:
//   - dut_in=idx; settle counter increments each cycle.
//   - After SETTLE cycles in DRIVE -> SAMPLE.
//  SAMPLE (exactly 1 cycle):
//   - Compare dut_out with EXPECTED[idx].
//   - On mismatch: set fail_map[idx] and increment err_count.
//   - If idx==VEC_N-1 -> DONE (idx holds; no wrap).
//   - Otherwise idx+1, settle counter cleared -> DRIVE.
//  DONE (1 cycle):
//   - done=1; pass=(err_count==0), registered on entry; dut_in holds the last code.
//   - Next state IDLE; idx cleared.
//  Timing: start sampled at edge 0.
//   - Code k is driven from cycle k*(SETTLE+1)+1 and sampled in cycle (k+1)*(SETTLE+1).
//   - done is high in cycle VEC_N*(SETTLE+1)+1 (=41 for defaults).
//  Boundaries:
//   - start while busy or in DONE is ignored, with no restart.
//   - start held high continuously re-arms on each return to IDLE.
//   - Reset mid-sweep aborts: all outputs 0; the partial fail_map is discarded.
//   - err_count cannot overflow: width IN_W+1 holds VEC_N.
//   - dut_out is sampled only in SAMPLE; glitches during DRIVE are ignored.
// STRUCTURE
//  Shared package fun_test_pkg:
//   - state encoding IDLE/DRIVE/SAMPLE/DONE (2 bits).
//   - localparam VEC_N = 2**IN_W.
//   - default EXPECTED constant.
//  One natural sub-module, settle_timer:
//   - load/count/expire counter of width $clog2(SETTLE+1).
//   - expire pulse after SETTLE cycles.
//  FSM, index register and scoreboard (fail_map, err_count, pass) stay in the top module.
// TESTING
//  T1 golden DUT (3-input XOR), start pulse:
//   - dut_in steps 0..7, each held 5 cycles.
//   - done pulse at cycle 41; pass=1, err_count=0, fail_map=8'h00.
//  T2 DUT output forced to 0:
//   - mismatches on codes 1,2,4,7.
//   - done: pass=0, err_count=4, fail_map=8'h96.
//  T3 reset asserted at cycle 17 of a sweep:
//   - next cycle all outputs 0 and state IDLE.
//   - a new start gives a full 41-cycle sweep.
//  T4 start pulsed again at cycles 5 and 41 during a sweep:
//   - ignored; exactly one done pulse, at cycle 41.
//  T5 start held high:
//   - back-to-back sweeps; second done 42 cycles after the first.
//   - fail_map and err_count cleared at each restart.
//  T6 SETTLE=1, DUT glitching between samples:
//   - done at cycle 17.
//   - result reflects only the SAMPLE-cycle values.

Source files
------------

// File: rtl/fun_test_pkg.sv
// Shared types and defaults for the fun block self-test sequencer.
package fun_test_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDrive  = 2'd1,
        StSample = 2'd2,
        StDone   = 2'd3
    } state_t;

    localparam int unsigned DEF_IN_W = 3;
    localparam int unsigned VEC_N    = 2 ** DEF_IN_W;
    // Odd parity of the three inputs
    localparam logic [VEC_N-1:0] DEF_EXPECTED = 8'b1001_0110;

endpackage

// File: rtl/settle_timer.sv
// Counts cycles while enabled; o_expire is high in the SETTLE-th enabled cycle.
module settle_timer #(
    parameter int unsigned SETTLE = 4
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire
);

    localparam int unsigned CNT_W = $clog2(SETTLE + 1);

    logic [CNT_W-1:0] r_count;

    assign o_expire = i_en && (r_count == CNT_W'(SETTLE - 1));

    always_ff @(posedge i_clock) begin
        if (i_reset || i_load) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fun_sweep_checker.sv
// Sweeps every input code of the fun block, samples its output after a settle
// time and scores it against a golden truth table.
module fun_sweep_checker
    import fun_test_pkg::*;
#(
    parameter int unsigned          IN_W     = DEF_IN_W,
    parameter int unsigned          SETTLE   = 4,
    parameter logic [2**IN_W-1:0]   EXPECTED = DEF_EXPECTED
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_start,
    output logic [IN_W-1:0]     o_dut_in,
    input  logic                i_dut_out,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_pass,
    output logic [IN_W:0]       o_err_count,
    output logic [2**IN_W-1:0]  o_fail_map
);

    localparam int unsigned N_CODES = 2 ** IN_W;

    state_t              r_state;
    state_t              w_state_d;
    logic [IN_W-1:0]     r_idx;
    logic [IN_W:0]       r_err_count;
    logic [IN_W:0]       w_err_next;
    logic [N_CODES-1:0]  r_fail_map;
    logic                r_pass;
    logic                w_expire;
    logic                w_mismatch;
    logic                w_last;

    settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_load   (r_state != StDrive),
        .i_en     (r_state == StDrive),
        .o_expire (w_expire)
    );

    assign w_mismatch = (i_dut_out != EXPECTED[r_idx]);
    assign w_last     = (r_idx == IN_W'(N_CODES - 1));
    assign w_err_next = r_err_count + {{IN_W{1'b0}}, w_mismatch};

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle:   if (i_start) w_state_d = StDrive;
            StDrive:  if (w_expire) w_state_d = StSample;
            StSample: w_state_d = w_last ? StDone : StDrive;
            StDone:   w_state_d = StIdle;
            default:  w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_idx       <= '0;
            r_err_count <= '0;
            r_fail_map  <= '0;
            r_pass      <= 1'b0;
        end else begin
            r_state <= w_state_d;
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_idx       <= '0;
                        r_err_count <= '0;
                        r_fail_map  <= '0;
                        r_pass      <= 1'b0;
                    end
                end
                StSample: begin
                    if (w_mismatch) begin
                        r_fail_map[r_idx] <= 1'b1;
                        r_err_count       <= w_err_next;
                    end
                    // Pass must include the verdict of the final code sampled this cycle
                    if (w_last) begin
                        r_pass <= (w_err_next == '0);
                    end else begin
                        r_idx <= r_idx + IN_W'(1);
                    end
                end
                StDone: r_idx <= '0;
                default: ;
            endcase
        end
    end

    assign o_dut_in    = (r_state == StIdle) ? '0 : r_idx;
    assign o_busy      = (r_state == StDrive) || (r_state == StSample);
    assign o_done      = (r_state == StDone);
    assign o_pass      = r_pass;
    assign o_err_count = r_err_count;
    assign o_fail_map  = r_fail_map;

endmodule
